aes_key_expand_dec: RTL and testbench

//  AES-128 key-expansion store feeding round keys to the decryption datapath.
//  - Expands one 128-bit cipher key into round keys 0..10, one round per clock.
//  - Holds the keys in an internal 11 x 128 store.
//  - Serves any key by index, so the inverse rounds can fetch keys 10..0.
//  - The final inverse round uses key 0 for its AddRoundKey.

---
 rtl/aes_key_expand_dec.sv | 175 +++++++++++++++++
 tb/tb_aes_key_expand_dec.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_dec.sv
// aes_key_expand_dec
//   AES-128 key-expansion store for the decryption datapath. A start pulse
//   captures the cipher key as round key 0. The block then derives round keys
//   1..10, one per clock, into an 11 x 128 store. Any key can be read by index,
//   so the inverse rounds can walk the keys from 10 down to 0.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous reset, active-high
//     iKeyStart   1-cycle pulse: capture iCipherKey and start expansion
//     iCipherKey  128-bit cipher key, FIPS-197 byte 0 at [127:120]
//     iRoundIdx   round-key index to read (0..10; 11..15 read as zero)
//     oRoundKey   round key selected by iRoundIdx (registered when READ_REG=1)
//     oBusy       expansion in progress
//     oKeyReady   all 11 round keys valid
module aes_key_expand_dec #(
  parameter int NR       = 10,
  parameter bit READ_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iKeyStart,
  input  logic [127:0] iCipherKey,
  input  logic [3:0]   iRoundIdx,
  output logic [127:0] oRoundKey,
  output logic         oBusy,
  output logic         oKeyReady
);

  localparam int NKEYS = NR + 1;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;
  logic [127:0]   slot_q [0:NKEYS-1];
  logic [127:0]   slot_d [0:NKEYS-1];

  logic [31:0]    w0, w1, w2, w3, t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;
  logic [127:0]   rd_data;

  // One full key-schedule step per clock, S-box lookups included.
  always_comb begin
    w0       = work_q[127:96];
    w1       = work_q[95:64];
    w2       = work_q[63:32];
    w3       = work_q[31:0];
    t_word   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    slot_d  = slot_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iKeyStart) begin
          slot_d[0] = iCipherKey;
          work_d    = iCipherKey;
          rcon_d    = 8'h01;
          cnt_d     = 4'd1;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          state_d   = S_EXPAND;
        end
      end
      S_EXPAND: begin
        work_d = next_key;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + 4'd1;
        for (int unsigned i = 1; i < NKEYS; i++) begin
          if (cnt_q == 4'(i)) slot_d[i] = next_key;
        end
        if (cnt_q == 4'(NR)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rcon_q  <= 8'h01;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < NKEYS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      for (int unsigned i = 0; i < NKEYS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Index decode by compare so indices past the store read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (iRoundIdx == 4'(i)) rd_data = slot_q[i];
    end
  end

  generate
    if (READ_REG) begin : g_read_reg
      logic [127:0] rkey_q, rkey_d;
      always_comb rkey_d = rd_data;
      always_ff @(posedge clk) begin
        if (rst) rkey_q <= '0;
        else     rkey_q <= rkey_d;
      end
      assign oRoundKey = rkey_q;
    end else begin : g_read_comb
      assign oRoundKey = rd_data;
    end
  endgenerate

  assign oBusy     = busy_q;
  assign oKeyReady = ready_q;

endmodule

// File: tb/tb_aes_key_expand_dec.sv
// tb_aes_key_expand_dec
//   Directed bench for aes_key_expand_dec with the registered read port.
//   Expected round keys are FIPS-197 reference values.
module tb_aes_key_expand_dec;

  logic         clk;
  logic         rst;
  logic         iKeyStart;
  logic [127:0] iCipherKey;
  logic [3:0]   iRoundIdx;
  logic [127:0] oRoundKey;
  logic         oBusy;
  logic         oKeyReady;

  int unsigned  n_tests;
  int unsigned  n_fail;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expand_dec #(
    .NR       (10),
    .READ_REG (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iKeyStart  (iKeyStart),
    .iCipherKey (iCipherKey),
    .iRoundIdx  (iRoundIdx),
    .oRoundKey  (oRoundKey),
    .oBusy      (oBusy),
    .oKeyReady  (oKeyReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_key(input logic [3:0] idx);
    iRoundIdx = idx;
    tick();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    iKeyStart  = 1'b0;
    iCipherKey = '0;
    iRoundIdx  = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy",  128'(oBusy), 128'd0);
    check("rst_ready", 128'(oKeyReady), 128'd0);
    check("rst_key",   oRoundKey, '0);

    // Test 1/2: FIPS key expansion, timing of busy/ready
    iRoundIdx  = 4'd1;
    iCipherKey = KEY_A;
    iKeyStart  = 1'b1;
    tick();                                   // edge T
    iKeyStart  = 1'b0;
    iCipherKey = '0;
    check("t1_busy_T",  128'(oBusy), 128'd1);
    check("t1_ready_T", 128'(oKeyReady), 128'd0);
    tick();                                   // T+1: slot1 written, read sees old value
    check("t1_same_edge_old", oRoundKey, '0);
    tick();                                   // T+2
    check("t1_idx1_early", oRoundKey, A_K1);
    for (int k = 3; k <= 9; k++) begin
      tick();
      check($sformatf("t1_busy_T+%0d", k),  128'(oBusy), 128'd1);
      check($sformatf("t1_ready_T+%0d", k), 128'(oKeyReady), 128'd0);
    end
    tick();                                   // T+10
    check("t1_busy_T+10",  128'(oBusy), 128'd0);
    check("t1_ready_T+10", 128'(oKeyReady), 128'd1);
    iRoundIdx = 4'd10;
    #1;
    check("t2_latency_old", oRoundKey, A_K1);
    tick();
    check("t1_idx10", oRoundKey, A_K10);
    read_key(4'd0);
    check("t1_idx0", oRoundKey, KEY_A);
    read_key(4'd1);
    check("t1_idx1", oRoundKey, A_K1);

    // Test 3: second start during expansion is ignored
    iCipherKey = KEY_A;
    iKeyStart  = 1'b1;
    tick();                                   // T
    iKeyStart  = 1'b0;
    for (int k = 1; k <= 3; k++) tick();      // T+3
    iCipherKey = KEY_B;
    iKeyStart  = 1'b1;
    tick();                                   // T+4
    iKeyStart  = 1'b0;
    check("t3_busy_T+4", 128'(oBusy), 128'd1);
    for (int k = 5; k <= 9; k++) begin
      tick();
      check($sformatf("t3_ready_T+%0d", k), 128'(oKeyReady), 128'd0);
    end
    tick();                                   // T+10
    check("t3_ready_T+10", 128'(oKeyReady), 128'd1);
    read_key(4'd10);
    check("t3_idx10", oRoundKey, A_K10);
    read_key(4'd0);
    check("t3_idx0", oRoundKey, KEY_A);

    // Test 4: reset mid-expansion
    iCipherKey = KEY_B;
    iKeyStart  = 1'b1;
    tick();                                   // T
    iKeyStart  = 1'b0;
    for (int k = 1; k <= 4; k++) tick();      // T+4
    rst = 1'b1;
    tick();                                   // T+5
    rst = 1'b0;
    check("t4_busy",  128'(oBusy), 128'd0);
    check("t4_ready", 128'(oKeyReady), 128'd0);
    check("t4_key",   oRoundKey, '0);
    read_key(4'd0);
    check("t4_idx0", oRoundKey, '0);
    read_key(4'd3);
    check("t4_idx3", oRoundKey, '0);
    read_key(4'd10);
    check("t4_idx10", oRoundKey, '0);
    check("t4_idle_busy", 128'(oBusy), 128'd0);
    iCipherKey = KEY_A;
    iKeyStart  = 1'b1;
    tick();
    iKeyStart  = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check("t4_ready_after", 128'(oKeyReady), 128'd1);
    read_key(4'd1);
    check("t4_idx1", oRoundKey, A_K1);
    read_key(4'd10);
    check("t4_idx10_after", oRoundKey, A_K10);

    // Test 5: out-of-range indices, re-expand from DONE with a new key
    for (int i = 11; i <= 15; i++) begin
      read_key(4'(i));
      check($sformatf("t5_oob_idx%0d", i), oRoundKey, '0);
    end
    iRoundIdx  = 4'd10;
    iCipherKey = KEY_B;
    iKeyStart  = 1'b1;
    tick();                                   // T
    iKeyStart  = 1'b0;
    check("t5_ready_T", 128'(oKeyReady), 128'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("t5_ready_T+%0d", k), 128'(oKeyReady), 128'd0);
    end
    tick();                                   // T+10
    check("t5_ready_T+10", 128'(oKeyReady), 128'd1);
    read_key(4'd10);
    check("t5_idx10", oRoundKey, B_K10);
    read_key(4'd0);
    check("t5_idx0", oRoundKey, KEY_B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
